// File: rtl/prog_encode_loader.sv
// Purpose : turns semantic instruction descriptors into 32-bit ISA words and writes them into instruction memory.
// Latency : a descriptor accepted at edge N is written (imem_we) during cycle N+1; back-to-back accepts stream.
// Backpres: in_ready is high only in LOAD; a session ends on HALT, an illegal descriptor or the last address.
//
// Ports: clk/rst (sync, active-high); start/base_addr open a session; in_* is the descriptor stream;
//        imem_we/imem_addr/imem_wdata is the memory write port; busy/done/err/err_code/word_count report status.
module prog_encode_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [3:0]        in_alu,
    input  logic [1:0]        in_cond,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [25:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    localparam logic [2:0] K_RALU  = 3'd0;
    localparam logic [2:0] K_IALU  = 3'd1;
    localparam logic [2:0] K_LD    = 3'd2;
    localparam logic [2:0] K_SW    = 3'd3;
    localparam logic [2:0] K_BR    = 3'd4;
    localparam logic [2:0] K_BCOND = 3'd5;
    localparam logic [2:0] K_HALT  = 3'd6;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_ptr;
    logic               we_q;
    logic               pend_halt;
    logic               pend_last;
    logic               accept;
    logic               addr_last;
    logic [31:0]        enc_word;
    logic               enc_ok;
    logic               enc_halt;
    logic [5:0]         funct;
    logic [5:0]         iop;

    assign accept    = in_valid & in_ready;
    assign addr_last = (addr_ptr == {ADDR_W{1'b1}});

    // Descriptor encoder. A zero funct/iop marks an ALU code that has no
    // encoding in that instruction class.
    always_comb begin
        funct = 6'd0;
        case (in_alu)
            4'd0:    funct = 6'd1;   // ADD
            4'd1:    funct = 6'd2;   // SUB
            4'd2:    funct = 6'd3;   // AND
            4'd3:    funct = 6'd4;   // OR
            4'd4:    funct = 6'd5;   // XOR
            4'd12:   funct = 6'd6;   // NOR
            4'd5:    funct = 6'd7;   // SL
            4'd6:    funct = 6'd8;   // SRL
            4'd9:    funct = 6'd9;   // SRA
            4'd7:    funct = 6'd10;  // SLT
            4'd13:   funct = 6'd11;  // SGT
            4'd8:    funct = 6'd12;  // NOT
            4'd10:   funct = 6'd13;  // INC
            4'd11:   funct = 6'd14;  // DEC
            4'd15:   funct = 6'd15;  // HAM
            default: funct = 6'd0;   // LUI has no register form
        endcase
    end

    always_comb begin
        iop = 6'd0;
        case (in_alu)
            4'd0:    iop = 6'd1;    // ADD
            4'd1:    iop = 6'd2;    // SUB
            4'd2:    iop = 6'd3;    // AND
            4'd3:    iop = 6'd4;    // OR
            4'd4:    iop = 6'd5;    // XOR
            4'd8:    iop = 6'd12;   // NOT
            4'd10:   iop = 6'd13;   // INC
            4'd11:   iop = 6'd14;   // DEC
            4'd15:   iop = 6'd15;   // HAM
            4'd14:   iop = 6'd16;   // LUI
            default: iop = 6'd0;    // shifts, compares, NOR have no immediate form
        endcase
    end

    always_comb begin
        enc_word = 32'd0;
        enc_ok   = 1'b1;
        enc_halt = 1'b0;
        case (in_kind)
            K_RALU: begin
                enc_ok   = (funct != 6'd0);
                enc_word = {6'd0, in_rs, in_rt, in_rd, 5'd0, funct};
            end
            K_IALU: begin
                enc_ok   = (iop != 6'd0);
                enc_word = {iop, in_rs, in_rt, in_imm[15:0]};
            end
            K_LD:    enc_word = {6'd17, in_rs, in_rt, in_imm[15:0]};
            K_SW:    enc_word = {6'd18, in_rs, in_rt, in_imm[15:0]};
            K_BR:    enc_word = {6'd32, in_imm};
            K_BCOND: begin
                // cond 1/2/3 map onto consecutive opcodes 33/34/35
                enc_ok   = (in_cond != 2'd0);
                enc_word = {6'd32 + {4'd0, in_cond}, in_rs, 5'd0, in_imm[15:0]};
            end
            K_HALT: begin
                enc_halt = 1'b1;
                enc_word = {6'd36, 26'd0};
            end
            default: enc_ok = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next state. LOAD is left on the accepting edge so in_ready drops
    // before any further descriptor can slip in behind the final word.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (accept) begin
                    if (!enc_ok)       state_nxt = S_ERR;
                    else if (enc_halt) state_nxt = S_DONE;
                    else if (addr_last) state_nxt = S_ERR;
                end
            end
            default: begin
                if (start) state_nxt = S_LOAD;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready = (state == S_LOAD);
        busy     = (state == S_LOAD) | we_q;
    end

    // Gating with rst keeps a write already staged from reaching memory
    // when reset lands in the write cycle.
    assign imem_we = we_q & ~rst;

    // Write pipeline and session status
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_ptr   <= '0;
            we_q       <= 1'b0;
            pend_halt  <= 1'b0;
            pend_last  <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'd0;
            word_count <= '0;
        end else begin
            we_q <= 1'b0;
            // Completion status appears the cycle after the write strobe.
            if (we_q) begin
                if (pend_halt) begin
                    done <= 1'b1;
                end else if (pend_last) begin
                    err      <= 1'b1;
                    err_code <= 2'd2;
                end
            end
            if (start && state != S_LOAD) begin
                addr_ptr   <= base_addr;
                done       <= 1'b0;
                err        <= 1'b0;
                err_code   <= 2'd0;
                word_count <= '0;
            end else if (accept) begin
                if (enc_ok) begin
                    we_q       <= 1'b1;
                    imem_addr  <= addr_ptr;
                    imem_wdata <= enc_word;
                    pend_halt  <= enc_halt;
                    pend_last  <= addr_last;
                    addr_ptr   <= addr_ptr + 1'b1;
                    word_count <= word_count + 1'b1;
                end else begin
                    err      <= 1'b1;
                    err_code <= 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_encode_loader.sv
// Purpose : directed checks of prog_encode_loader (ADDR_W=10 main instance, ADDR_W=2 overflow instance).
// Latency : writes are expected the cycle after each accept; status flags the cycle after the write.
// Backpres: in_ready is expected to follow the session state only.
module tb_prog_encode_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_s;
    logic [9:0]  base_addr;
    logic [1:0]  base_s;
    logic        in_valid;
    logic [2:0]  in_kind;
    logic [3:0]  in_alu;
    logic [1:0]  in_cond;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [25:0] in_imm;

    logic        in_ready, imem_we, busy, done, err;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [1:0]  err_code;
    logic [10:0] word_count;

    logic        in_ready_s, imem_we_s, busy_s, done_s, err_s;
    logic [1:0]  imem_addr_s;
    logic [31:0] imem_wdata_s;
    logic [1:0]  err_code_s;
    logic [2:0]  word_count_s;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    prog_encode_loader #(.ADDR_W(10)) u_dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_alu(in_alu),
        .in_cond(in_cond), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .word_count(word_count)
    );

    prog_encode_loader #(.ADDR_W(2)) u_dut_small (
        .clk(clk), .rst(rst), .start(start_s), .base_addr(base_s),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_kind(in_kind), .in_alu(in_alu),
        .in_cond(in_cond), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .imem_we(imem_we_s), .imem_addr(imem_addr_s), .imem_wdata(imem_wdata_s),
        .busy(busy_s), .done(done_s), .err(err_s), .err_code(err_code_s), .word_count(word_count_s)
    );

    // Descriptor table with hand-encoded expected words
    logic [2:0]  t_kind [10];
    logic [3:0]  t_alu  [10];
    logic [1:0]  t_cond [10];
    logic [4:0]  t_rs   [10];
    logic [4:0]  t_rt   [10];
    logic [4:0]  t_rd   [10];
    logic [25:0] t_imm  [10];
    logic [31:0] t_exp  [10];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_desc(input logic [2:0] k, input logic [3:0] a, input logic [1:0] c,
                            input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                            input logic [25:0] imm);
        in_kind = k; in_alu = a; in_cond = c; in_rs = s; in_rt = t; in_rd = d; in_imm = imm;
    endtask

    task automatic put_entry(input int idx, input logic [2:0] k, input logic [3:0] a,
                             input logic [1:0] c, input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d, input logic [25:0] imm, input logic [31:0] e);
        t_kind[idx] = k; t_alu[idx] = a; t_cond[idx] = c; t_rs[idx] = s;
        t_rt[idx] = t; t_rd[idx] = d; t_imm[idx] = imm; t_exp[idx] = e;
    endtask

    // Stream table entries lo..hi back-to-back with in_valid held high.
    task automatic stream(input int lo, input int hi, input int base);
        for (int i = lo; i <= hi; i++) begin
            set_desc(t_kind[i], t_alu[i], t_cond[i], t_rs[i], t_rt[i], t_rd[i], t_imm[i]);
            in_valid = 1'b1;
            tick();
            chk($sformatf("we[%0d]", i), 64'(imem_we), 64'd1);
            chk($sformatf("addr[%0d]", i), 64'(imem_addr), 64'(base + i - lo));
            chk($sformatf("data[%0d]", i), 64'(imem_wdata), 64'(t_exp[i]));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int gap;
        put_entry(0, 3'd1, 4'd0,  2'd0, 5'd0,  5'd5, 5'd0, 26'h0000010, 32'h04050010);
        put_entry(1, 3'd5, 4'd0,  2'd3, 5'd4,  5'd0, 5'd0, 26'h000FFFC, 32'h8C80FFFC);
        put_entry(2, 3'd4, 4'd0,  2'd0, 5'd0,  5'd0, 5'd0, 26'h0000010, 32'h80000010);
        put_entry(3, 3'd6, 4'd0,  2'd0, 5'd0,  5'd0, 5'd0, 26'h0000000, 32'h90000000);
        put_entry(4, 3'd0, 4'd1,  2'd0, 5'd3,  5'd4, 5'd5, 26'h0000000, 32'h00642802);
        put_entry(5, 3'd2, 4'd0,  2'd0, 5'd2,  5'd7, 5'd0, 26'h0031234, 32'h44471234);
        put_entry(6, 3'd3, 4'd0,  2'd0, 5'd1,  5'd9, 5'd0, 26'h0008000, 32'h48298000);
        put_entry(7, 3'd1, 4'd14, 2'd0, 5'd0,  5'd3, 5'd0, 26'h000ABCD, 32'h4003ABCD);
        put_entry(8, 3'd0, 4'd12, 2'd0, 5'd0,  5'd0, 5'd1, 26'h0000000, 32'h00000806);
        put_entry(9, 3'd5, 4'd0,  2'd1, 5'd31, 5'd0, 5'd0, 26'h0000001, 32'h87E00001);

        rst = 1'b1; start = 1'b0; start_s = 1'b0; base_addr = '0; base_s = '0; in_valid = 1'b0;
        set_desc(3'd0, 4'd0, 2'd0, 5'd0, 5'd0, 5'd0, 26'd0);
        repeat (3) tick();

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);

        // Single R-ALU ADD
        rst = 1'b0; start = 1'b1; base_addr = 10'd0;
        tick();
        start = 1'b0;
        chk("load_in_ready", 64'(in_ready), 64'd1);
        chk("load_busy", 64'(busy), 64'd1);
        set_desc(3'd0, 4'd0, 2'd0, 5'd1, 5'd2, 5'd3, 26'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("radd_we", 64'(imem_we), 64'd1);
        chk("radd_addr", 64'(imem_addr), 64'd0);
        chk("radd_data", 64'(imem_wdata), 64'h00221801);
        chk("radd_count", 64'(word_count), 64'd1);
        tick();
        chk("radd_we_one_cycle", 64'(imem_we), 64'd0);

        // Back-to-back stream ending in HALT
        rst = 1'b1; tick(); rst = 1'b0;
        start = 1'b1; base_addr = 10'd0; tick(); start = 1'b0;
        stream(0, 3, 0);
        chk("halt_in_ready", 64'(in_ready), 64'd0);
        chk("halt_done_not_yet", 64'(done), 64'd0);
        tick();
        chk("halt_done", 64'(done), 64'd1);
        chk("halt_we_off", 64'(imem_we), 64'd0);
        chk("halt_count", 64'(word_count), 64'd4);
        chk("halt_busy", 64'(busy), 64'd0);

        // New session from DONE, remaining encodings, truncation of imm[25:16]
        start = 1'b1; base_addr = 10'd8; tick(); start = 1'b0;
        chk("restart_done_clr", 64'(done), 64'd0);
        chk("restart_count_clr", 64'(word_count), 64'd0);
        stream(4, 9, 8);
        tick();
        chk("stream2_count", 64'(word_count), 64'd6);

        // Illegal: I-ALU with SL
        set_desc(3'd1, 4'd5, 2'd0, 5'd1, 5'd1, 5'd0, 26'd1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill_we", 64'(imem_we), 64'd0);
        chk("ill_err", 64'(err), 64'd1);
        chk("ill_code", 64'(err_code), 64'd1);
        chk("ill_in_ready", 64'(in_ready), 64'd0);
        start = 1'b1; base_addr = 10'd20; tick(); start = 1'b0;
        chk("ill_restart_err", 64'(err), 64'd0);
        chk("ill_restart_code", 64'(err_code), 64'd0);
        chk("ill_restart_ready", 64'(in_ready), 64'd1);
        stream(4, 4, 20);
        tick();
        // Illegal: BCOND with cond 0
        set_desc(3'd5, 4'd0, 2'd0, 5'd2, 5'd0, 5'd0, 26'd4);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("cond0_we", 64'(imem_we), 64'd0);
        chk("cond0_code", 64'(err_code), 64'd1);

        // Overflow on the ADDR_W=2 instance (main instance sits in ERR)
        start_s = 1'b1; base_s = 2'd2; tick(); start_s = 1'b0;
        set_desc(3'd1, 4'd0, 2'd0, 5'd0, 5'd1, 5'd0, 26'd1);
        in_valid = 1'b1;
        tick();
        chk("ovf_we0", 64'(imem_we_s), 64'd1);
        chk("ovf_addr0", 64'(imem_addr_s), 64'd2);
        set_desc(3'd1, 4'd0, 2'd0, 5'd0, 5'd2, 5'd0, 26'd2);
        tick();
        chk("ovf_we1", 64'(imem_we_s), 64'd1);
        chk("ovf_addr1", 64'(imem_addr_s), 64'd3);
        chk("ovf_data1", 64'(imem_wdata_s), 64'h04020002);
        chk("ovf_ready_off", 64'(in_ready_s), 64'd0);
        chk("ovf_err_not_yet", 64'(err_s), 64'd0);
        set_desc(3'd1, 4'd0, 2'd0, 5'd0, 5'd3, 5'd0, 26'd3);
        tick();
        chk("ovf_err", 64'(err_s), 64'd1);
        chk("ovf_code", 64'(err_code_s), 64'd2);
        chk("ovf_we_off", 64'(imem_we_s), 64'd0);
        repeat (2) tick();
        chk("ovf_third_not_taken", 64'(word_count_s), 64'd2);
        chk("ovf_no_more_we", 64'(imem_we_s), 64'd0);
        in_valid = 1'b0;
        chk("main_idle_during_ovf", 64'(imem_we), 64'd0);

        // Reset the cycle after an accept
        start = 1'b1; base_addr = 10'd0; tick(); start = 1'b0;
        set_desc(3'd4, 4'd0, 2'd0, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_we_gated", 64'(imem_we), 64'd0);
        tick();
        chk("rstmid_we", 64'(imem_we), 64'd0);
        chk("rstmid_addr", 64'(imem_addr), 64'd0);
        chk("rstmid_wdata", 64'(imem_wdata), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_ready", 64'(in_ready), 64'd0);
        chk("rstmid_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        tick();
        chk("rstmid_still_idle", 64'(imem_we), 64'd0);

        // Random gaps with a start pulse mid-session
        start = 1'b1; base_addr = 10'd100; tick(); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_desc(3'd1, 4'd0, 2'd0, 5'd0, 5'(i), 5'd0, 26'(i * 3));
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("gap_we[%0d]", i), 64'(imem_we), 64'd1);
            chk($sformatf("gap_addr[%0d]", i), 64'(imem_addr), 64'(100 + i));
            chk($sformatf("gap_data[%0d]", i), 64'(imem_wdata),
                64'(32'h04000000 | (32'(i) << 16) | 32'(i * 3)));
            if (i == 2) begin
                start = 1'b1; base_addr = 10'd500;
                tick();
                start = 1'b0;
                chk("gap_start_ignored_we", 64'(imem_we), 64'd0);
                chk("gap_start_ignored_ready", 64'(in_ready), 64'd1);
            end
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
        end
        tick();
        chk("gap_count", 64'(word_count), 64'd6);
        chk("gap_err", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_encode_loader.md
Name: prog_encode_loader

Overview:
- Inverse of the processor's control decoder: accepts semantic instruction descriptors (operation kind, ALU code, registers, immediate) over a valid/ready stream.
- Encodes each descriptor into a 32-bit instruction word in the decoder's ISA format and writes it into instruction memory through a write port.
- Sits between the testbench/boot source and instruction memory. Stops on HALT, an illegal descriptor, or memory overflow.

Parameters:
- ADDR_W, 10, instruction-memory word-address width; depth = 2^ADDR_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begin load session at base_addr
- base_addr  in  ADDR_W  first write address
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid&in_ready
- in_kind  in  3  0=R-ALU, 1=I-ALU, 2=LD, 3=SW, 4=BR, 5=BCOND, 6=HALT, 7=illegal
- in_alu  in  4  ALU code: ADD0 SUB1 AND2 OR3 XOR4 SL5 SRL6 SLT7 NOT8 SRA9 INC10 DEC11 NOR12 SGT13 LUI14 HAM15
- in_cond  in  2  BCOND select: 1=BMI, 2=BPL, 3=BZ, 0=illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  26  immediate; [15:0] used except BR uses [25:0]
- imem_we  out  1  write strobe
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session in progress
- done  out  1  sticky; HALT written
- err  out  1  sticky; session aborted
- err_code  out  2  1=illegal descriptor, 2=overflow
- word_count  out  ADDR_W+1  words written this session

Behaviour:
- Reset: state IDLE. in_ready, imem_we, busy, done, err = 0. imem_addr, imem_wdata, err_code, word_count = 0. Reset mid-session aborts with no further writes.
- States: IDLE, LOAD, DONE, ERR.
- start is honoured in IDLE, DONE or ERR:
  - go to LOAD; next-address = base_addr.
  - clear done, err, err_code, word_count.
- start is ignored in LOAD.
- LOAD: in_ready = 1 (combinational from state only). In all other states in_ready = 0.
- Latency: descriptor accepted at edge N is written at cycle N+1:
  - imem_we = 1 for exactly one cycle, with imem_addr = next-address and imem_wdata = encoding.
  - next-address increments and word_count increments on that write.
  - Back-to-back accepts give back-to-back writes.
- Encoding fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6] = 0, funct[5:0], imm16[15:0], imm26[25:0]. All unused bits are 0.
- R-ALU: op = 0, funct from in_alu:
  - ADD1 SUB2 AND3 OR4 XOR5 NOR6 SL7 SRL8 SRA9 SLT10 SGT11 NOT12 INC13 DEC14 HAM15.
  - LUI is illegal.
- I-ALU: rs/rt/imm16, op from in_alu:
  - ADD1 SUB2 AND3 OR4 XOR5 NOT12 INC13 DEC14 HAM15 LUI16.
  - NOR, SL, SRL, SRA, SLT, SGT are illegal.
- LD: op = 17 (rs base, rt dest, imm16). SW: op = 18 (rs base, rt source, imm16).
- BR: op = 32, imm26.
- BCOND: op = 33/34/35 for BMI/BPL/BZ, with rs and imm16.
- HALT: op = 36, word 0x90000000.
- Illegal descriptor (kind 7, disallowed ALU code, or cond = 0) accepted in LOAD:
  - no write.
  - next state ERR; err = 1, err_code = 1.
- HALT accepted: word is written; next state DONE; done = 1 in the cycle after the write strobe.
- Overflow: a non-HALT word written at address 2^ADDR_W−1 moves the block to ERR with err_code = 2, one cycle after the write. A HALT at the last address goes to DONE.
- Address never wraps within a session.
- busy = 1 in LOAD and while a pending write is outstanding.
- Truncation: in_imm[25:16] is ignored for imm16 kinds, without error.

Test Plan:
- Reset, start with base_addr = 0, then R-ALU ADD rs=1 rt=2 rd=3 -> one write, addr 0, data 0x00221801, word_count = 1.
- Back-to-back, in_valid held high:
  - I-ALU ADD rt=5 rs=0 imm=0x0010 -> addr 0, data 0x04050010.
  - BCOND BZ rs=4 imm=0xFFFC -> addr 1, data 0x8C80FFFC.
  - BR imm26=0x10 -> addr 2, data 0x80000010.
  - HALT -> addr 3, data 0x90000000, then done = 1, in_ready = 0.
- I-ALU with in_alu = SL -> no imem_we, err = 1, err_code = 1, in_ready = 0. A new start clears err and resumes at base_addr.
- ADDR_W = 2, base_addr = 2, three non-HALT descriptors:
  - writes at addresses 2 and 3, then err_code = 2.
  - the third descriptor is never accepted.
- rst asserted the cycle after an accept -> no imem_we at all, all outputs 0.
- in_valid toggled with random gaps and start pulsed while in LOAD -> the start has no effect, and writes are contiguous in accept order.
